// File: rtl/rggen_apb_adapter_pkg.sv
// Shared definitions for the APB register-block adapter: FSM states, bus status and access codes.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package rggen_apb_adapter_pkg;

    // Register-side response status codes; bit 1 set means the access failed.
    localparam logic [1:0] RGGEN_OKAY   = 2'b00;
    localparam logic [1:0] RGGEN_EXOKAY = 2'b01;
    localparam logic [1:0] RGGEN_SLVERR = 2'b10;

    // Access direction as presented on o_register_access.
    localparam logic RGGEN_READ  = 1'b0;
    localparam logic RGGEN_WRITE = 1'b1;

    // Adapter transaction states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // Status reported for accesses that hit no register (outside the block or unmapped).
    function automatic logic [1:0] unmapped_status(input bit report_error);
        return report_error ? RGGEN_SLVERR : RGGEN_OKAY;
    endfunction

endpackage

// File: rtl/rggen_apb_adapter_or_reducer.sv
// Merges read data and status of all registers that claim the current address.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the merged result is sampled.
module rggen_or_reducer #(
    parameter int BUS_WIDTH = 32,
    parameter int REGISTERS = 1
) (
    input  logic [REGISTERS-1:0]           i_active,
    input  logic [2*REGISTERS-1:0]         i_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_read_data,
    output logic [BUS_WIDTH-1:0]           o_read_data,
    output logic [1:0]                     o_status
);

    // Only registers that decode the address contribute; idle registers may drive anything.
    always_comb begin
        o_read_data = '0;
        o_status    = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (i_active[i]) begin
                o_read_data = o_read_data | i_read_data[i*BUS_WIDTH +: BUS_WIDTH];
                o_status    = o_status | i_status[2*i +: 2];
            end
        end
    end

endmodule

// File: rtl/rggen_apb_adapter.sv
// APB slave front end that turns APB transfers into rggen register-interface accesses.
// Latency: setup cycle, >=1 register cycle, pready on the 3rd cycle; out-of-range pready on the 2nd.
// Backpressure: holds the register request stable until an active register is ready; no timeout.
module rggen_apb_adapter
    import rggen_apb_adapter_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH       = 16,
    parameter int                     LOCAL_ADDRESS_WIDTH = 8,
    parameter int                     BUS_WIDTH           = 32,
    parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
    parameter int                     BYTE_SIZE           = 256,
    parameter bit                     ERROR_STATUS        = 1'b0,
    parameter int                     REGISTERS           = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_psel,
    input  logic                           i_penable,
    input  logic                           i_pwrite,
    input  logic [2:0]                     i_pprot,
    input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
    input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
    input  logic [BUS_WIDTH-1:0]           i_pwdata,
    output logic                           o_pready,
    output logic [BUS_WIDTH-1:0]           o_prdata,
    output logic                           o_pslverr,
    output logic                           o_register_valid,
    output logic                           o_register_access,
    output logic [LOCAL_ADDRESS_WIDTH-1:0] o_register_address,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    output logic [BUS_WIDTH-1:0]           o_register_strobe,
    input  logic [REGISTERS-1:0]           i_register_active,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

    localparam int                     STRB_WIDTH = BUS_WIDTH / 8;
    // One extra bit so base + span never wraps inside the range check.
    localparam logic [ADDRESS_WIDTH:0] LP_BASE    = {1'b0, BASE_ADDRESS};
    localparam logic [ADDRESS_WIDTH:0] LP_SIZE    = (ADDRESS_WIDTH+1)'(BYTE_SIZE);
    localparam logic [1:0]             LP_UNMAPPED = unmapped_status(ERROR_STATUS);

    state_e                         r_state;
    logic                           r_pready;
    logic [BUS_WIDTH-1:0]           r_prdata;
    logic                           r_pslverr;
    logic                           r_valid;
    logic                           r_access;
    logic [LOCAL_ADDRESS_WIDTH-1:0] r_address;
    logic [BUS_WIDTH-1:0]           r_write_data;
    logic [BUS_WIDTH-1:0]           r_strobe;

    logic [ADDRESS_WIDTH:0]         w_paddr;
    logic [ADDRESS_WIDTH:0]         w_offset;
    logic                           w_in_range;
    logic [BUS_WIDTH-1:0]           w_strobe;
    logic                           w_hit;
    logic                           w_none_active;
    logic [BUS_WIDTH-1:0]           w_red_data;
    logic [1:0]                     w_red_status;
    logic                           w_unused_ok;

    assign w_paddr       = {1'b0, i_paddr};
    assign w_offset      = w_paddr - LP_BASE;
    assign w_in_range    = (w_paddr >= LP_BASE) && (w_offset < LP_SIZE);
    assign w_hit         = |(i_register_active & i_register_ready);
    assign w_none_active = ~|i_register_active;

    // Protection attributes and penable carry no information for this block; status bit 0
    // (EXOKAY) does not map onto APB.
    assign w_unused_ok = &{1'b0, i_penable, i_pprot, w_red_status[0]};

    // Byte enables widen to a bit mask on writes; reads touch every bit.
    for (genvar g = 0; g < STRB_WIDTH; g++) begin : g_strobe
        assign w_strobe[g*8 +: 8] = (i_pwrite == RGGEN_WRITE) ? {8{i_pstrb[g]}} : 8'hFF;
    end

    rggen_or_reducer #(
        .BUS_WIDTH (BUS_WIDTH),
        .REGISTERS (REGISTERS)
    ) u_or_reducer (
        .i_active    (i_register_active),
        .i_status    (i_register_status),
        .i_read_data (i_register_read_data),
        .o_read_data (w_red_data),
        .o_status    (w_red_status)
    );

    // Transaction FSM; every APB and register-side output is a flop updated here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_pready     <= 1'b0;
            r_prdata     <= '0;
            r_pslverr    <= 1'b0;
            r_valid      <= 1'b0;
            r_access     <= 1'b0;
            r_address    <= '0;
            r_write_data <= '0;
            r_strobe     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pready  <= 1'b0;
                    r_prdata  <= '0;
                    r_pslverr <= 1'b0;
                    if (i_psel) begin
                        if (w_in_range) begin
                            r_state      <= ST_BUSY;
                            r_valid      <= 1'b1;
                            r_access     <= i_pwrite;
                            r_address    <= w_offset[LOCAL_ADDRESS_WIDTH-1:0];
                            r_write_data <= i_pwdata;
                            r_strobe     <= w_strobe;
                        end else begin
                            // Outside the block: answer directly without touching registers.
                            r_state   <= ST_ACK;
                            r_pready  <= 1'b1;
                            r_prdata  <= '0;
                            r_pslverr <= LP_UNMAPPED[1];
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_hit) begin
                        r_state   <= ST_ACK;
                        r_valid   <= 1'b0;
                        r_pready  <= 1'b1;
                        r_prdata  <= (r_access == RGGEN_WRITE) ? '0 : w_red_data;
                        r_pslverr <= w_red_status[1];
                    end else if (w_none_active) begin
                        // Inside the block but no register decodes this offset.
                        r_state   <= ST_ACK;
                        r_valid   <= 1'b0;
                        r_pready  <= 1'b1;
                        r_prdata  <= '0;
                        r_pslverr <= LP_UNMAPPED[1];
                    end
                end
                ST_ACK: begin
                    r_state   <= ST_IDLE;
                    r_pready  <= 1'b0;
                    r_prdata  <= '0;
                    r_pslverr <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_valid   <= 1'b0;
                    r_pready  <= 1'b0;
                    r_prdata  <= '0;
                    r_pslverr <= 1'b0;
                end
            endcase
        end
    end

    assign o_pready              = r_pready;
    assign o_prdata              = r_prdata;
    assign o_pslverr             = r_pslverr;
    assign o_register_valid      = r_valid;
    assign o_register_access     = r_access;
    assign o_register_address    = r_address;
    assign o_register_write_data = r_write_data;
    assign o_register_strobe     = r_strobe;

endmodule

// File: tb/tb_rggen_apb_adapter.sv
// Self-checking bench for rggen_apb_adapter: directed vector table, reset and back-to-back
// sequences, then random transfers scored against a transfer-level reference model.
module tb_rggen_apb_adapter;

    localparam logic [15:0] BASE     = 16'h1000;
    localparam int          SIZE     = 256;
    localparam bit          ERR_STAT = 1'b1;
    localparam int          PERIOD   = 10;

    logic        clk;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [2:0]  pprot;
    logic [15:0] paddr;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic        o_pready;
    logic [31:0] o_prdata;
    logic        o_pslverr;
    logic        o_register_valid;
    logic        o_register_access;
    logic [7:0]  o_register_address;
    logic [31:0] o_register_write_data;
    logic [31:0] o_register_strobe;
    logic [1:0]  active, ready;
    logic [3:0]  status;
    logic [63:0] read_data;

    rggen_apb_adapter #(
        .ADDRESS_WIDTH       (16),
        .LOCAL_ADDRESS_WIDTH (8),
        .BUS_WIDTH           (32),
        .BASE_ADDRESS        (BASE),
        .BYTE_SIZE           (SIZE),
        .ERROR_STATUS        (ERR_STAT),
        .REGISTERS           (2)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_psel                (psel),
        .i_penable             (penable),
        .i_pwrite              (pwrite),
        .i_pprot               (pprot),
        .i_paddr               (paddr),
        .i_pstrb               (pstrb),
        .i_pwdata              (pwdata),
        .o_pready              (o_pready),
        .o_prdata              (o_prdata),
        .o_pslverr             (o_pslverr),
        .o_register_valid      (o_register_valid),
        .o_register_access     (o_register_access),
        .o_register_address    (o_register_address),
        .o_register_write_data (o_register_write_data),
        .o_register_strobe     (o_register_strobe),
        .i_register_active     (active),
        .i_register_ready      (ready),
        .i_register_status     (status),
        .i_register_read_data  (read_data)
    );

    initial clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observations of the most recent transfer.
    logic [31:0] res_prdata;
    logic        res_pslverr;
    int          res_cycle;
    int          res_valid;
    logic [7:0]  res_addr;
    logic        res_acc;
    logic [31:0] res_strb;
    logic [31:0] res_wd;
    bit          res_hold_bad;
    bit          res_zero_bad;
    time         t_start, t_end;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  pstrb;
        logic [1:0]  mask;
        int          wait_n;
        logic [31:0] rd0, rd1;
        logic [1:0]  st0, st1;
        logic [31:0] e_prdata;
        logic        e_pslverr;
        int          e_cycle;
        int          e_valid;
        logic [31:0] e_strobe;
        logic [7:0]  e_addr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic wr, input logic [3:0] sb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = (!wr || sb[i]) ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Acts as APB master and as the register bank. Starts on the negedge after the caller's
    // position, returns on the negedge where pready was seen (with psel dropped).
    task automatic run_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                            input logic [3:0] sb, input logic [1:0] mask, input int wait_n,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input logic [1:0] s0, input logic [1:0] s1);
        bit got;
        got = 0;
        @(negedge clk);
        chk("pready_single", 32'(o_pready), 0);
        t_start = $time;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = sb;
        pprot = 3'($urandom_range(0, 7));
        active = '0; ready = '0; read_data = {rd1, rd0}; status = {s1, s0};
        res_valid = 0; res_cycle = 0; res_prdata = '0; res_pslverr = 1'b0;
        res_hold_bad = 0; res_zero_bad = 0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            penable = 1'b1;
            if (o_pready) begin
                got = 1;
                res_cycle = c + 2;
                res_prdata = o_prdata;
                res_pslverr = o_pslverr;
                t_end = $time;
            end else begin
                if (o_prdata !== 32'h0 || o_pslverr !== 1'b0) res_zero_bad = 1;
                if (o_register_valid) begin
                    res_valid++;
                    if (res_valid == 1) begin
                        res_addr = o_register_address;
                        res_acc  = o_register_access;
                        res_strb = o_register_strobe;
                        res_wd   = o_register_write_data;
                    end else if (o_register_address !== res_addr || o_register_access !== res_acc ||
                                 o_register_strobe !== res_strb || o_register_write_data !== res_wd) begin
                        res_hold_bad = 1;
                    end
                    active = mask;
                    ready  = (res_valid > wait_n) ? mask : ~mask;
                end else begin
                    active = '0;
                    ready  = '0;
                end
            end
        end
        chk("pready_seen", 32'(got), 1);
        psel = 1'b0; penable = 1'b0; active = '0; ready = '0;
    endtask

    task automatic check_result(input string tag, input logic wr, input logic [31:0] wd,
                                input logic [31:0] e_prdata, input logic e_pslverr,
                                input int e_cycle, input int e_valid,
                                input logic [31:0] e_strobe, input logic [7:0] e_addr);
        chk({tag, ".prdata"}, res_prdata, e_prdata);
        chk({tag, ".pslverr"}, 32'(res_pslverr), 32'(e_pslverr));
        chk({tag, ".pready_cycle"}, res_cycle, e_cycle);
        chk({tag, ".valid_cycles"}, res_valid, e_valid);
        if (e_valid > 0) begin
            chk({tag, ".address"}, 32'(res_addr), 32'(e_addr));
            chk({tag, ".access"}, 32'(res_acc), 32'(wr));
            chk({tag, ".strobe"}, res_strb, e_strobe);
            if (wr) chk({tag, ".wdata"}, res_wd, wd);
        end
        chk({tag, ".hold"}, 32'(res_hold_bad), 0);
        chk({tag, ".idle_zero"}, 32'(res_zero_bad), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pready"}, 32'(o_pready), 0);
        chk({tag, ".prdata"}, o_prdata, 0);
        chk({tag, ".pslverr"}, 32'(o_pslverr), 0);
        chk({tag, ".valid"}, 32'(o_register_valid), 0);
        chk({tag, ".access"}, 32'(o_register_access), 0);
        chk({tag, ".address"}, 32'(o_register_address), 0);
        chk({tag, ".wdata"}, o_register_write_data, 0);
        chk({tag, ".strobe"}, o_register_strobe, 0);
    endtask

    initial begin
        logic [15:0] ra;
        logic        rwr;
        logic [31:0] rwd, rd0, rd1, por, ep, estr;
        logic [3:0]  rsb;
        logic [1:0]  rmask, s0, s1, sor;
        logic        es;
        int          rw, ec, ev, kind;
        bit          ain, seen;
        time         t_first;

        vecs[0] = '{1'b1, 16'h1004, 32'hA5A5A5A5, 4'b0011, 2'b10, 0, 32'hDEADBEEF, 32'h0, 2'b00, 2'b00,
                    32'h0, 1'b0, 3, 1, 32'h0000FFFF, 8'h04};
        vecs[1] = '{1'b0, 16'h1008, 32'h0, 4'h0, 2'b01, 3, 32'h12345678, 32'hFFFF0000, 2'b10, 2'b00,
                    32'h12345678, 1'b1, 6, 4, 32'hFFFFFFFF, 8'h08};
        vecs[2] = '{1'b0, 16'h1100, 32'h0, 4'h0, 2'b01, 0, 32'hCAFEF00D, 32'h0, 2'b00, 2'b00,
                    32'h0, 1'b1, 2, 0, 32'h0, 8'h00};
        vecs[3] = '{1'b0, 16'h1010, 32'h0, 4'h0, 2'b00, 0, 32'h11111111, 32'h22222222, 2'b00, 2'b00,
                    32'h0, 1'b1, 3, 1, 32'hFFFFFFFF, 8'h10};
        vecs[4] = '{1'b1, 16'h0FFF, 32'h55AA55AA, 4'hF, 2'b01, 0, 32'h1, 32'h0, 2'b00, 2'b00,
                    32'h0, 1'b1, 2, 0, 32'h0, 8'h00};
        vecs[5] = '{1'b0, 16'h10FF, 32'h0, 4'h0, 2'b11, 1, 32'h000000F0, 32'h0F00000F, 2'b01, 2'b00,
                    32'h0F0000FF, 1'b0, 4, 2, 32'hFFFFFFFF, 8'hFF};
        vecs[6] = '{1'b1, 16'h1000, 32'h11223344, 4'b1010, 2'b01, 2, 32'h9999, 32'h0, 2'b10, 2'b00,
                    32'h0, 1'b1, 5, 3, 32'hFF00FF00, 8'h00};
        vecs[7] = '{1'b1, 16'h1020, 32'hFEEDFACE, 4'hF, 2'b11, 0, 32'h1, 32'h2, 2'b00, 2'b10,
                    32'h0, 1'b1, 3, 1, 32'hFFFFFFFF, 8'h20};

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pprot = 3'b0;
        paddr = '0; pstrb = '0; pwdata = '0; active = '0; ready = '0; status = '0; read_data = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].pstrb, vecs[i].mask,
                     vecs[i].wait_n, vecs[i].rd0, vecs[i].rd1, vecs[i].st0, vecs[i].st1);
            check_result($sformatf("vec%0d", i), vecs[i].wr, vecs[i].wdata, vecs[i].e_prdata,
                         vecs[i].e_pslverr, vecs[i].e_cycle, vecs[i].e_valid, vecs[i].e_strobe,
                         vecs[i].e_addr);
        end

        // Back-to-back writes: the second setup follows the first pready cycle directly.
        run_xfer(1'b1, 16'h1030, 32'hAAAA0001, 4'hF, 2'b01, 0, 32'h0, 32'h0, 2'b00, 2'b00);
        check_result("b2b_first", 1'b1, 32'hAAAA0001, 32'h0, 1'b0, 3, 1, 32'hFFFFFFFF, 8'h30);
        t_first = t_end;
        run_xfer(1'b1, 16'h1034, 32'hBBBB0002, 4'b0101, 2'b10, 0, 32'h0, 32'h0, 2'b00, 2'b00);
        chk("b2b.gap_cycles", 32'((t_start - t_first) / PERIOD), 1);
        check_result("b2b_second", 1'b1, 32'hBBBB0002, 32'h0, 1'b0, 3, 1, 32'h00FF00FF, 8'h34);

        // Reset while the register side is stalled in BUSY.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h1044; pwdata = 32'h77;
        pstrb = 4'hF; active = 2'b01; ready = 2'b00;
        @(negedge clk);
        penable = 1'b1;
        chk("rstbusy.valid_before", 32'(o_register_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstbusy");
        psel = 1'b0; penable = 1'b0; active = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_pready) seen = 1;
        end
        chk("rstbusy.no_pready", 32'(seen), 0);

        // Reset while pready is up.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h1048;
        active = 2'b01; ready = 2'b01; read_data = {32'h0, 32'h5A5A0F0F}; status = 4'b0000;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        chk("rstack.pready_before", 32'(o_pready), 1);
        chk("rstack.prdata_before", o_prdata, 32'h5A5A0F0F);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstack");
        psel = 1'b0; penable = 1'b0; active = '0; ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_pready) seen = 1;
        end
        chk("rstack.no_pready", 32'(seen), 0);

        // Random transfers scored against a transfer-level model.
        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 7)      ra = 16'(32'h1000 + $urandom_range(0, 255));
            else if (kind < 8) ra = 16'(32'h0FFF - $urandom_range(0, 255));
            else               ra = 16'(32'h1100 + $urandom_range(0, 1000));
            rwr   = 1'($urandom_range(0, 1));
            rwd   = $urandom;
            rsb   = 4'($urandom_range(0, 15));
            rmask = 2'($urandom_range(0, 3));
            rw    = int'($urandom_range(0, 4));
            rd0   = $urandom;
            rd1   = $urandom;
            s0    = 2'($urandom_range(0, 2));
            s1    = 2'($urandom_range(0, 2));

            ain = (int'(ra) >= int'(BASE)) && (int'(ra) < int'(BASE) + SIZE);
            if (!ain) begin
                ep = 32'h0; es = ERR_STAT; ec = 2; ev = 0;
            end else if (rmask == 2'b00) begin
                ep = 32'h0; es = ERR_STAT; ec = 3; ev = 1;
            end else begin
                por = 32'h0; sor = 2'b00;
                if (rmask[0]) begin por = por | rd0; sor = sor | s0; end
                if (rmask[1]) begin por = por | rd1; sor = sor | s1; end
                ep = rwr ? 32'h0 : por;
                es = sor[1];
                ec = rw + 3;
                ev = rw + 1;
            end
            estr = lane_mask(rwr, rsb);
            run_xfer(rwr, ra, rwd, rsb, rmask, rw, rd0, rd1, s0, s1);
            check_result($sformatf("rnd%0d", n), rwr, rwd, ep, es, ec, ev, estr,
                         8'(int'(ra) - int'(BASE)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
